// File: rtl/bsg_wormhole_router_packet_builder.sv
// bsg_wormhole_router_packet_builder
//
// Transmit-side framer for a wormhole link. One header flit is taken, then
// exactly len payload words, where len is read from the header itself. The
// result goes out as a single packet of 1+len flits on a valid/ready link.
// Packet boundaries are enforced here, so the router never sees a malformed
// packet.
//
// Parameters:
//   flit_width_p        width of header, data and link flits (set by the
//                       instantiating design)
//   payload_len_bits_p  width of the payload length field (set by the
//                       instantiating design)
//   len_offset_p        LSB of the length field inside header_i
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   header_v_i/header_i       header flit offer
//   header_ready_o            header accepted when header_v_i is also high
//   data_v_i/data_i           payload word offer
//   data_ready_o              payload word accepted when data_v_i is also high
//   link_v_o/link_data_o      flit toward the router
//   link_ready_i              router accepts the flit
//   link_first_o/link_last_o  current flit is header / final flit of packet
//   busy_o                    registered, high while a packet body is pending
module bsg_wormhole_router_packet_builder #(
  parameter int flit_width_p       = 32,
  parameter int payload_len_bits_p = 8,
  parameter int len_offset_p       = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    header_v_i,
  input  logic [flit_width_p-1:0] header_i,
  output logic                    header_ready_o,
  input  logic                    data_v_i,
  input  logic [flit_width_p-1:0] data_i,
  output logic                    data_ready_o,
  output logic                    link_v_o,
  output logic [flit_width_p-1:0] link_data_o,
  input  logic                    link_ready_i,
  output logic                    link_first_o,
  output logic                    link_last_o,
  output logic                    busy_o
);

  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_e;

  localparam logic [payload_len_bits_p-1:0] RemOne = payload_len_bits_p'(1);

  state_e                        state_q, state_d;
  logic [payload_len_bits_p-1:0] rem_q, rem_d;
  logic [payload_len_bits_p-1:0] hdrLen;
  logic                          linkV;
  logic                          linkFire;

  assign hdrLen = header_i[len_offset_p +: payload_len_bits_p];

  // Output mux: the current state picks which source faces the link. The
  // ready seen by the router is passed straight back to that source only.
  // While reset is held, no valid or ready may escape, even though the
  // header mux stays selected.
  always_comb begin
    linkV          = 1'b0;
    link_data_o    = header_i;
    link_first_o   = 1'b1;
    link_last_o    = (hdrLen == '0);
    header_ready_o = 1'b0;
    data_ready_o   = 1'b0;
    case (state_q)
      HDR: begin
        linkV          = header_v_i;
        header_ready_o = link_ready_i;
      end
      BODY: begin
        linkV        = data_v_i;
        link_data_o  = data_i;
        link_first_o = 1'b0;
        link_last_o  = (rem_q == RemOne);
        data_ready_o = link_ready_i;
      end
      default: ;
    endcase
    if (!reset_n_i) begin
      linkV          = 1'b0;
      header_ready_o = 1'b0;
      data_ready_o   = 1'b0;
    end
  end

  assign link_v_o = linkV;
  assign linkFire = linkV & link_ready_i;

  // Next state: the state and rem only move on a link handshake. A
  // zero-length header is a complete packet by itself, so the block stays
  // in HDR for it. rem is only decremented while it is >= 1, so it never
  // wraps, even for the largest length.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      HDR: begin
        if (linkFire && (hdrLen != '0)) begin
          rem_d   = hdrLen;
          state_d = BODY;
        end
      end
      BODY: begin
        if (linkFire) begin
          rem_d = rem_q - RemOne;
          if (rem_q == RemOne) begin
            state_d = HDR;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= HDR;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign busy_o = (state_q == BODY);

endmodule

// File: tb/tb_bsg_wormhole_router_packet_builder.sv
// Testbench for bsg_wormhole_router_packet_builder.
// A packet list is turned into three queues: the header source, the data
// source, and the flit stream the link should carry. The expected link
// behaviour in any cycle follows from whether the next expected flit is a
// header or a body word.
module tb_bsg_wormhole_router_packet_builder;

  localparam int FW  = 16;
  localparam int LB  = 4;
  localparam int OFS = 4;

  typedef struct packed {
    logic          first;
    logic          last;
    logic [FW-1:0] data;
  } flit_t;

  logic          clock = 1'b0;
  logic          resetN;
  logic          headerV, dataV, linkReady;
  logic [FW-1:0] headerIn, dataIn;
  logic          headerReady, dataReady, linkV, linkFirst, linkLast, busy;
  logic [FW-1:0] linkData;

  logic [FW-1:0] hdrQ[$];
  logic [FW-1:0] dataQ[$];
  flit_t         expQ[$];

  int assertCount = 0;
  int failCount   = 0;
  int busyCount;
  int cycles;

  always #5 clock = ~clock;

  bsg_wormhole_router_packet_builder #(
    .flit_width_p      (FW),
    .payload_len_bits_p(LB),
    .len_offset_p      (OFS)
  ) dut (
    .clk_i         (clock),
    .reset_n_i     (resetN),
    .header_v_i    (headerV),
    .header_i      (headerIn),
    .header_ready_o(headerReady),
    .data_v_i      (dataV),
    .data_i        (dataIn),
    .data_ready_o  (dataReady),
    .link_v_o      (linkV),
    .link_data_o   (linkData),
    .link_ready_i  (linkReady),
    .link_first_o  (linkFirst),
    .link_last_o   (linkLast),
    .busy_o        (busy)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Build one packet: header with the length field set, then len words.
  task automatic addPacket(input int len);
    logic [FW-1:0] h;
    logic [FW-1:0] d;
    flit_t         f;
    h = FW'($urandom);
    h[OFS +: LB] = LB'(len);
    hdrQ.push_back(h);
    f.first = 1'b1;
    f.last  = (len == 0);
    f.data  = h;
    expQ.push_back(f);
    for (int i = 0; i < len; i++) begin
      d = FW'($urandom);
      dataQ.push_back(d);
      f.first = 1'b0;
      f.last  = (i == len - 1);
      f.data  = d;
      expQ.push_back(f);
    end
  endtask

  // Drive sources and the router ready for up to maxCycles cycles, or until
  // the expected stream drains. readyMode: 0 always ready, 1 toggling
  // starting high, 2 random. Called and returns at posedge + 1.
  task automatic applyStimulus(input int readyMode, input int validPct,
                               input int maxCycles, output int used);
    logic nextIsHdr;
    logic expV;
    used      = 0;
    busyCount = 0;
    while (expQ.size() > 0 && used < maxCycles) begin
      headerV  = (hdrQ.size() > 0) && ($urandom_range(99) < validPct);
      headerIn = headerV ? hdrQ[0] : FW'($urandom);
      dataV    = (dataQ.size() > 0) && ($urandom_range(99) < validPct);
      dataIn   = dataV ? dataQ[0] : FW'($urandom);
      case (readyMode)
        0:       linkReady = 1'b1;
        1:       linkReady = (used % 2 == 0);
        default: linkReady = ($urandom_range(99) < 70);
      endcase
      @(negedge clock);
      nextIsHdr = expQ[0].first;
      expV      = nextIsHdr ? headerV : dataV;
      checkOutput("link_v", 32'(linkV), 32'(expV));
      checkOutput("header_ready", 32'(headerReady), 32'(nextIsHdr & linkReady));
      checkOutput("data_ready", 32'(dataReady), 32'(!nextIsHdr & linkReady));
      checkOutput("busy", 32'(busy), 32'(!nextIsHdr));
      if (busy) busyCount++;
      if (expV) begin
        checkOutput("link_data", 32'(linkData), 32'(expQ[0].data));
        checkOutput("link_first", 32'(linkFirst), 32'(expQ[0].first));
        checkOutput("link_last", 32'(linkLast), 32'(expQ[0].last));
        if (linkReady) begin
          void'(expQ.pop_front());
          if (nextIsHdr) void'(hdrQ.pop_front());
          else void'(dataQ.pop_front());
        end
      end
      used++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clearQueues();
    hdrQ.delete();
    dataQ.delete();
    expQ.delete();
  endtask

  initial begin
    resetN    = 1'b0;
    headerV   = 1'b1;
    headerIn  = 16'h00A5;
    dataV     = 1'b1;
    dataIn    = 16'h1234;
    linkReady = 1'b1;
    #12;
    checkOutput("reset link_v", 32'(linkV), 32'd0);
    checkOutput("reset header_ready", 32'(headerReady), 32'd0);
    checkOutput("reset data_ready", 32'(dataReady), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset first", 32'(linkFirst), 32'd1);
    @(posedge clock);
    #1;
    resetN = 1'b1;

    // len=3, full throughput: H,D0,D1,D2 in 4 cycles, busy for 3
    addPacket(3);
    applyStimulus(0, 100, 20, cycles);
    checkOutput("t1 drain", 32'(expQ.size()), 32'd0);
    checkOutput("t1 cycles", 32'(cycles), 32'd4);
    checkOutput("t1 busy cycles", 32'(busyCount), 32'd3);

    // len=0 then len=1, no bubble between packets
    clearQueues();
    addPacket(0);
    addPacket(1);
    applyStimulus(0, 100, 20, cycles);
    checkOutput("t2 drain", 32'(expQ.size()), 32'd0);
    checkOutput("t2 cycles", 32'(cycles), 32'd3);

    // len=2 with ready toggling 1,0,1,0,1
    clearQueues();
    addPacket(2);
    applyStimulus(1, 100, 20, cycles);
    checkOutput("t3 drain", 32'(expQ.size()), 32'd0);
    checkOutput("t3 cycles", 32'(cycles), 32'd5);

    // maximum length: 16 flits, last on the 16th
    clearQueues();
    addPacket(15);
    applyStimulus(0, 100, 40, cycles);
    checkOutput("t4 drain", 32'(expQ.size()), 32'd0);
    checkOutput("t4 cycles", 32'(cycles), 32'd16);

    // random traffic: gaps on both sources, random router ready
    clearQueues();
    for (int p = 0; p < 25; p++) addPacket($urandom_range(15));
    applyStimulus(2, 60, 4000, cycles);
    checkOutput("t5 drain", 32'(expQ.size()), 32'd0);

    // reset after one of three body flits
    clearQueues();
    addPacket(3);
    applyStimulus(0, 100, 2, cycles);
    checkOutput("t6 pre busy", 32'(busy), 32'd1);
    headerV   = 1'b1;
    dataV     = 1'b1;
    linkReady = 1'b1;
    resetN    = 1'b0;
    #1;
    checkOutput("t6 rst link_v", 32'(linkV), 32'd0);
    checkOutput("t6 rst header_ready", 32'(headerReady), 32'd0);
    checkOutput("t6 rst data_ready", 32'(dataReady), 32'd0);
    checkOutput("t6 rst busy", 32'(busy), 32'd0);
    checkOutput("t6 rst first", 32'(linkFirst), 32'd1);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    clearQueues();
    addPacket(2);
    applyStimulus(0, 100, 20, cycles);
    checkOutput("t6 drain", 32'(expQ.size()), 32'd0);
    checkOutput("t6 cycles", 32'(cycles), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
